matrix_operand_feeder: RTL

Operand source for the 4x4 matrix multiplier. Accepts matrices A and B from a host as a 32-word valid/ready stream, holds them in eight 4-entry lanes (A rows, B columns), and answers the multiplier controller's per-lane read strobes with one registered element per strobe. Sits between the host load path and the systolic array inputs. Its `operands_ready` output drives the controller's `start`, and the controller's `done` returns it to load mode.

---
 rtl/matrix_pkg.sv | 9 +
 rtl/operand_lane.sv | 43 ++++
 rtl/matrix_operand_feeder.sv | 109 ++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and state type for the 4x4 matrix multiplier datapath.
package matrix_pkg;

    localparam int N          = 4;
    localparam int LOAD_WORDS = 32;

    typedef enum logic {LOAD, FEED} feeder_state_t;

endpackage

// File: rtl/operand_lane.sv
// One 4-entry operand buffer: host write port, pop-driven registered output,
// saturating read pointer (4 = empty, pops then yield 0).
module operand_lane
    import matrix_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [N];
    logic [2:0]        ptr_q;

    // Storage write; contents survive clear and are simply overwritten on reload.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read pointer and output register; an empty lane answers a pop with 0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr_q <= 3'd0;
            rdata <= '0;
        end else if (pop) begin
            if (ptr_q[2]) begin
                rdata <= '0;
            end else begin
                rdata <= mem[ptr_q[1:0]];
                ptr_q <= ptr_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/matrix_operand_feeder.sv
// Loads A (row lanes) and B (column lanes) from a 32-word host stream, then
// serves per-lane pop strobes from the multiplier controller until done.
module matrix_operand_feeder
    import matrix_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic              operands_ready,
    input  logic              done_in,
    input  logic              rdA1,
    input  logic              rdA2,
    input  logic              rdA3,
    input  logic              rdA4,
    input  logic              rdB1,
    input  logic              rdB2,
    input  logic              rdB3,
    input  logic              rdB4,
    output logic [DATA_W-1:0] a_data1,
    output logic [DATA_W-1:0] a_data2,
    output logic [DATA_W-1:0] a_data3,
    output logic [DATA_W-1:0] a_data4,
    output logic [DATA_W-1:0] b_data1,
    output logic [DATA_W-1:0] b_data2,
    output logic [DATA_W-1:0] b_data3,
    output logic [DATA_W-1:0] b_data4
);

    feeder_state_t     state_q, state_d;
    logic [4:0]        w_q;
    logic              accept;
    logic              feed_done;
    logic [N-1:0]      rd_a, rd_b;
    logic [DATA_W-1:0] a_out [N];
    logic [DATA_W-1:0] b_out [N];

    assign load_ready     = (state_q == LOAD);
    assign operands_ready = (state_q == FEED);
    assign accept         = load_valid && load_ready;
    assign feed_done      = operands_ready && done_in;

    assign rd_a = {rdA4, rdA3, rdA2, rdA1};
    assign rd_b = {rdB4, rdB3, rdB2, rdB1};

    // Next state: last word moves to FEED, done returns to LOAD.
    always_comb begin
        state_d = state_q;
        if (accept && (w_q == 5'(LOAD_WORDS - 1))) begin
            state_d = FEED;
        end else if (feed_done) begin
            state_d = LOAD;
        end
    end

    // State and write index; the index wraps to 0 after word 31.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
            w_q     <= 5'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                w_q <= w_q + 5'd1;
            end else if (feed_done) begin
                w_q <= 5'd0;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        // A word w<16 goes to row lane w[3:2], entry w[1:0].
        operand_lane #(.DATA_W(DATA_W)) u_a_lane (
            .clk   (clk),
            .reset (reset),
            .clear (feed_done),
            .we    (accept && !w_q[4] && (w_q[3:2] == 2'(i))),
            .waddr (w_q[1:0]),
            .wdata (load_data),
            .pop   (rd_a[i] && operands_ready && !done_in),
            .rdata (a_out[i])
        );

        // B word is row-major B[k][j]: column lane j = w[1:0], entry k = w[3:2].
        operand_lane #(.DATA_W(DATA_W)) u_b_lane (
            .clk   (clk),
            .reset (reset),
            .clear (feed_done),
            .we    (accept && w_q[4] && (w_q[1:0] == 2'(i))),
            .waddr (w_q[3:2]),
            .wdata (load_data),
            .pop   (rd_b[i] && operands_ready && !done_in),
            .rdata (b_out[i])
        );
    end

    assign a_data1 = a_out[0];
    assign a_data2 = a_out[1];
    assign a_data3 = a_out[2];
    assign a_data4 = a_out[3];
    assign b_data1 = b_out[0];
    assign b_data2 = b_out[1];
    assign b_data3 = b_out[2];
    assign b_data4 = b_out[3];

endmodule
